// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing generator. It divides the system clock down to a pixel
//   strobe, then counts pixels across a line (hc) and lines down a frame
//   (vc). The sync, visible-area and end-of-line/frame flags are decoded
//   from those counters.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset. Release must already be
//                   synchronised to clk.
//   en         in   run enable. When low, the divider and both counters hold.
//   hc[9:0]    out  horizontal pixel count (register output)
//   vc[9:0]    out  vertical line count (register output)
//   hsync      out  horizontal sync, active low
//   vsync      out  vertical sync, active low
//   video_on   out  1 while (hc, vc) is inside the visible area
//   pixel_tick out  one-clk pixel strobe
//   line_end   out  one-clk pulse on the last pixel of a line
//   frame_end  out  one-clk pulse on the last pixel of a frame
//
// Downstream logic should use hc/vc only while video_on is high.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int CLK_DIV   = 4,
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic [9:0] hc,
   output logic [9:0] vc,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       pixel_tick,
   output logic       line_end,
   output logic       frame_end
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   // Sync window bounds can reach 1024 when a total is exactly 1024.
   // Compare in 11 bits so that those bounds do not alias to 0.
   localparam logic [10:0] H_VIS_LIM  = 11'(H_VISIBLE);
   localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FP);
   localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [10:0] V_VIS_LIM  = 11'(V_VISIBLE);
   localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FP);
   localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FP + V_SYNC);
   localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   // Catch illegal configurations at elaboration time.
   generate
      if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
         $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
      end
      if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
         $error("vga_timing_gen: CLK_DIV must be in 1..16");
      end
   endgenerate

   logic [DIV_W-1:0] div_cnt;
   logic [10:0]      hc_x;
   logic [10:0]      vc_x;

   // -------------------------------------------------------------------------
   // Strobes. All of them are gated by en, so they are all 0 while frozen.
   // When CLK_DIV == 1, div_cnt stays at 0 (equal to DIV_LAST), so
   // pixel_tick simply follows en.
   // -------------------------------------------------------------------------
   assign pixel_tick = en & (div_cnt == DIV_LAST);
   assign line_end   = pixel_tick & (hc == H_LAST);
   assign frame_end  = line_end & (vc == V_LAST);

   // Pixel divider. It holds its phase while en is low, so resuming
   // neither drops nor adds a pixel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (en) begin
         if (div_cnt == DIV_LAST) div_cnt <= '0;
         else                     div_cnt <= div_cnt + 1'b1;
      end
   end

   // Horizontal counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hc <= '0;
      end else if (pixel_tick) begin
         if (hc == H_LAST) hc <= '0;
         else              hc <= hc + 1'b1;
      end
   end

   // Vertical counter. It steps on the same edge on which hc wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vc <= '0;
      end else if (line_end) begin
         if (vc == V_LAST) vc <= '0;
         else              vc <= vc + 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // Decodes. These are purely combinational from the current counts, so
   // they stay in the same cycle as hc/vc and keep tracking while frozen.
   // -------------------------------------------------------------------------
   assign hc_x = {1'b0, hc};
   assign vc_x = {1'b0, vc};

   assign hsync    = ~((hc_x >= H_SYNC_BEG) && (hc_x < H_SYNC_END));
   assign vsync    = ~((vc_x >= V_SYNC_BEG) && (vc_x < V_SYNC_END));
   assign video_on = (hc_x < H_VIS_LIM) && (vc_x < V_VIS_LIM);

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the port list below names them.
REQ-002 Parameter CLK_DIV SHALL default to 4 and set the number of clk cycles per pixel; legal values are 1 to 16.
REQ-003 Parameters H_VISIBLE, H_FP, H_SYNC and H_BP SHALL default to 640, 16, 96 and 48.
REQ-004 Parameters V_VISIBLE, V_FP, V_SYNC and V_BP SHALL default to 480, 10, 2 and 33.
REQ-005 The port list SHALL be as follows:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable; 0 freezes all counters
- hc  out  10  horizontal pixel count
- vc  out  10  vertical line count
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video_on  out  1  1 when (hc, vc) is inside the visible area
- pixel_tick  out  1  one-clk pixel strobe
- line_end  out  1  one-clk pulse on the last pixel of each line
- frame_end  out  1  one-clk pulse on the last pixel of each frame

Function
REQ-006 H_TOTAL SHALL equal H_VISIBLE+H_FP+H_SYNC+H_BP (default 800).
REQ-007 V_TOTAL SHALL equal the sum of the four V parameters (default 525).
REQ-008 Both totals SHALL be at most 1024; a larger value SHALL be a elaboration-time error.
REQ-009 The divider div_cnt SHALL count 0..CLK_DIV-1 and wrap to 0, advancing on each clk edge where en=1.
REQ-010 pixel_tick SHALL be 1 exactly when div_cnt==CLK_DIV-1 and en=1.
REQ-011 When CLK_DIV=1, pixel_tick SHALL equal en.
REQ-012 hc SHALL advance by 1 on each clk edge where pixel_tick=1, and SHALL wrap from H_TOTAL-1 to 0.
REQ-013 vc SHALL advance by 1 only on the clk edge where pixel_tick=1 and hc==H_TOTAL-1, and SHALL wrap from V_TOTAL-1 to 0 on that same edge.
REQ-014 hc and vc SHALL be registers that drive the ports directly, with no added latency.
REQ-015 hsync SHALL be 0 when H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC (656..751 at defaults), and 1 otherwise.
REQ-016 vsync SHALL be 0 when V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC (490..491 at defaults), and 1 otherwise.
REQ-017 video_on SHALL be 1 when hc < H_VISIBLE and vc < V_VISIBLE.
REQ-018 hsync, vsync and video_on SHALL be combinational decodes of the current hc/vc registers, aligned in the same cycle as the hc/vc values they describe.
REQ-019 line_end SHALL equal pixel_tick AND (hc==H_TOTAL-1).
REQ-020 frame_end SHALL equal line_end AND (vc==V_TOTAL-1).
REQ-021 When en=0, div_cnt, hc and vc SHALL hold their values, and pixel_tick, line_end and frame_end SHALL be 0.
REQ-022 hsync, vsync and video_on SHALL keep decoding the held counts while en=0.
REQ-023 When en rises again, counting SHALL resume from the held div_cnt with no lost or extra pixel.
REQ-024 Downstream consumers SHALL use hc/vc only when video_on=1.
REQ-025 In the visible area, hc/20 is at most 31 and vc/20 is at most 23, so the downstream address range is 0..767.

Reset
REQ-026 While rst_n=0, the block SHALL asynchronously force div_cnt=0, hc=0 and vc=0.
REQ-027 The resulting reset output values SHALL be hsync=1, vsync=1, video_on=1, pixel_tick=0, line_end=0 and frame_end=0.
REQ-028 Reset release SHALL be synchronised externally; the first pixel_tick SHALL occur on the CLK_DIV-th clk cycle after release, with en=1.
REQ-029 If reset is asserted mid-frame, it SHALL override any in-progress count immediately, with no wait for a clk edge.

Verification
REQ-030 Defaults, en=1, run 2 frames -> pixel_tick period 4 clk, line_end period 3200 clk, frame_end period 1,680,000 clk, and exactly 1 frame_end per frame.
REQ-031 Observe one line -> hsync low for exactly 96 pixel_ticks starting at hc=656; video_on high for hc 0..639; hc wraps 799->0 on the same edge that line_end=1.
REQ-032 Observe one frame -> vsync low only for vc 490..491; video_on low for all vc 480..524; vc wraps 524->0 coincident with frame_end=1.
REQ-033 Drop en for 7 clk when hc=100 and div_cnt=2 -> hc, vc and div_cnt frozen; no strobes; after en returns, hc=101 exactly 2 clk later.
REQ-034 Assert rst_n=0 mid-clock at hc=700, vc=300 -> hc=0, vc=0, hsync=1 and video_on=1 without waiting for a clk edge; after release, first pixel_tick on clk 4.
REQ-035 CLK_DIV=1 with H/V parameters 4,1,2,1 and 3,1,1,1 -> H_TOTAL 8, V_TOTAL 6; frame_end every 48 clk; hsync low at hc 5..6; vsync low at vc 4.
